// File: rtl/tmr_pkg.sv
// Shared types and constants for the triple-redundant counter supervisor.
package tmr_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_RESYNC   = 2'd1,
    ST_DEGRADED = 2'd2,
    ST_FAILSAFE = 2'd3
  } tmr_state_t;

  localparam int R1 = 0;
  localparam int R2 = 1;
  localparam int R3 = 2;

  localparam int DEFAULT_WIDTH = 8;
  // Wide enough for the largest allowed permanent-mask threshold (15).
  localparam int CONSEC_W = 4;

  function automatic logic [1:0] count_ones(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/tmr_vote_mask.sv
// Combinational majority vote over the unmasked replicas, with per-replica
// disagreement flags that are only meaningful when a majority exists.
module tmr_vote_mask
  import tmr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] q_1,
  input  logic [WIDTH-1:0] q_2,
  input  logic [WIDTH-1:0] q_3,
  input  logic [2:0]       mask,
  output logic [WIDTH-1:0] vote,
  output logic             no_majority,
  output logic [2:0]       mis
);

  logic [WIDTH-1:0] q [3];
  logic             eq_12, eq_13, eq_23;

  assign q[R1] = q_1;
  assign q[R2] = q_2;
  assign q[R3] = q_3;

  // A pair only counts if neither member is masked, so a single masked
  // replica forces the remaining two to agree.
  assign eq_12 = !mask[R1] && !mask[R2] && (q_1 == q_2);
  assign eq_13 = !mask[R1] && !mask[R3] && (q_1 == q_3);
  assign eq_23 = !mask[R2] && !mask[R3] && (q_2 == q_3);

  always_comb begin
    vote        = '0;
    no_majority = 1'b1;
    if (eq_12 || eq_13) begin
      vote        = q_1;
      no_majority = 1'b0;
    end else if (eq_23) begin
      vote        = q_2;
      no_majority = 1'b0;
    end
  end

  always_comb begin
    mis = '0;
    for (int i = 0; i < 3; i++) begin
      mis[i] = !mask[i] && !no_majority && (q[i] != vote);
    end
  end

endmodule

// File: rtl/tmr_fault_manager.sv
// Supervisor for a triple-redundant counter cluster: votes, gates the shared
// enable, sequences resync, masks persistent failures and holds on no majority.
module tmr_fault_manager
  import tmr_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int PERM_THRESH = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] q_1,
  input  logic [WIDTH-1:0] q_2,
  input  logic [WIDTH-1:0] q_3,
  output logic             cnt_enable,
  output logic [2:0]       resync,
  output logic [WIDTH-1:0] voted_q,
  output logic [2:0]       mask,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] err_count,
  output logic             irq,
  input  logic             irq_ack,
  input  logic             clear
);

  tmr_state_t          st;
  logic [WIDTH-1:0]    vote;
  logic [WIDTH-1:0]    held;
  logic                no_majority;
  logic [2:0]          mis;
  logic [2:0]          thresh_hit;
  logic [2:0]          new_mask;
  logic [CONSEC_W-1:0] consec [3];

  tmr_vote_mask #(.WIDTH(WIDTH)) u_vote (
    .q_1         (q_1),
    .q_2         (q_2),
    .q_3         (q_3),
    .mask        (mask),
    .vote        (vote),
    .no_majority (no_majority),
    .mis         (mis)
  );

  always_comb begin
    thresh_hit = '0;
    for (int i = 0; i < 3; i++) begin
      thresh_hit[i] = !mask[i] && (consec[i] >= CONSEC_W'(PERM_THRESH));
    end
  end

  assign new_mask   = mask | thresh_hit;
  assign state      = st;
  assign voted_q    = (st == ST_FAILSAFE || no_majority) ? held : vote;
  // Combinational so the replicas never advance on a disagreeing cycle.
  assign cnt_enable = enable_in && (st == ST_NORMAL || st == ST_DEGRADED) &&
                      !no_majority && (mis == 3'b000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_NORMAL;
      mask      <= '0;
      resync    <= '0;
      irq       <= 1'b0;
      err_count <= '0;
      held      <= '0;
      for (int i = 0; i < 3; i++) consec[i] <= '0;
    end else begin
      if (!no_majority && st != ST_FAILSAFE) held <= vote;
      // Any set event below is assigned later and therefore beats the ack.
      if (irq_ack) irq <= 1'b0;

      if (clear) begin
        mask      <= '0;
        err_count <= '0;
        resync    <= 3'b111;
        st        <= ST_RESYNC;
        for (int i = 0; i < 3; i++) consec[i] <= '0;
      end else begin
        case (st)
          ST_NORMAL, ST_DEGRADED: begin
            resync <= '0;
            if (no_majority) begin
              st  <= ST_FAILSAFE;
              irq <= 1'b1;
            end else if (mis != 3'b000) begin
              resync <= mis;
              st     <= ST_RESYNC;
              if (err_count != '1) err_count <= err_count + CNT_W'(1);
              for (int i = 0; i < 3; i++) begin
                if (mis[i] && consec[i] != '1) consec[i] <= consec[i] + CONSEC_W'(1);
              end
            end else begin
              for (int i = 0; i < 3; i++) consec[i] <= '0;
            end
          end
          ST_RESYNC: begin
            resync <= '0;
            for (int i = 0; i < 3; i++) begin
              if (!mis[i]) consec[i] <= '0;
            end
            if (count_ones(new_mask) >= 2'd2) begin
              st  <= ST_FAILSAFE;
              irq <= 1'b1;
            end else if (new_mask != 3'b000) begin
              mask <= new_mask;
              st   <= ST_DEGRADED;
              irq  <= 1'b1;
            end else begin
              st <= ST_NORMAL;
            end
          end
          default: begin
            resync <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Directed bench for tmr_fault_manager with a spec-level reference model
// checked every cycle plus literal spot checks.
module tb_tmr_fault_manager;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_in, irq_ack, clear;
  logic [7:0] q_1, q_2, q_3;
  logic       cnt_enable, irq;
  logic [2:0] resync, mask;
  logic [7:0] voted_q, err_count;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  bit run      = 0;

  tmr_fault_manager #(.WIDTH(8), .PERM_THRESH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_in  (enable_in),
    .q_1        (q_1),
    .q_2        (q_2),
    .q_3        (q_3),
    .cnt_enable (cnt_enable),
    .resync     (resync),
    .voted_q    (voted_q),
    .mask       (mask),
    .state      (state),
    .err_count  (err_count),
    .irq        (irq),
    .irq_ack    (irq_ack),
    .clear      (clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state 0 NORMAL, 1 RESYNC, 2 DEGRADED, 3 FAILSAFE.
  int       m_st, m_err, m_held;
  int       m_consec [3];
  bit [2:0] m_mask, m_rs;
  bit       m_irq;

  function automatic void mvote(output bit ok, output int v, output bit [2:0] mis);
    int qa [3];
    int n;
    qa[0] = int'(q_1); qa[1] = int'(q_2); qa[2] = int'(q_3);
    ok = 0; v = 0; mis = '0;
    for (int i = 0; i < 3; i++) begin
      if (!m_mask[i]) begin
        n = 0;
        for (int j = 0; j < 3; j++) if (!m_mask[j] && qa[j] == qa[i]) n++;
        if (n >= 2) begin ok = 1; v = qa[i]; end
      end
    end
    for (int i = 0; i < 3; i++) mis[i] = ok && !m_mask[i] && qa[i] != v;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit       ok, set_irq;
    int       v, nbits;
    bit [2:0] mis, nm;
    if (rst) begin
      m_st = 0; m_err = 0; m_held = 0; m_mask = 0; m_rs = 0; m_irq = 0;
      for (int i = 0; i < 3; i++) m_consec[i] = 0;
    end else begin
      mvote(ok, v, mis);
      set_irq = 0;
      if (clear) begin
        m_mask = 0; m_err = 0; m_rs = 3'b111;
        for (int i = 0; i < 3; i++) m_consec[i] = 0;
      end else if (m_st == 0 || m_st == 2) begin
        m_rs = 0;
        if (!ok) set_irq = 1;
        else if (mis != 0) begin
          m_rs = mis;
          if (m_err < 255) m_err++;
          for (int i = 0; i < 3; i++) if (mis[i] && m_consec[i] < 15) m_consec[i]++;
        end else for (int i = 0; i < 3; i++) m_consec[i] = 0;
      end else if (m_st == 1) begin
        m_rs = 0;
        nm = m_mask;
        for (int i = 0; i < 3; i++) if (!m_mask[i] && m_consec[i] >= 4) nm[i] = 1;
        for (int i = 0; i < 3; i++) if (!mis[i]) m_consec[i] = 0;
        nbits = int'(nm[0]) + int'(nm[1]) + int'(nm[2]);
        if (nbits >= 2 || nbits == 1) set_irq = 1;
        if (nbits == 1) m_mask = nm;
      end else m_rs = 0;
      // Next state derived after the register updates above.
      if (ok && m_st != 3) m_held = v;
      if (clear) m_st = 1;
      else if (m_st == 0 || m_st == 2) m_st = !ok ? 3 : (mis != 0 ? 1 : m_st);
      else if (m_st == 1) m_st = (nbits >= 2) ? 3 : (nbits == 1 ? 2 : 0);
      if (set_irq) m_irq = 1;
      else if (irq_ack) m_irq = 0;
    end
  end

  always @(negedge clk) begin
    bit       ok;
    int       v;
    bit [2:0] mis;
    if (run && !rst) begin
      mvote(ok, v, mis);
      chk("cmp cnt_enable", cnt_enable, enable_in && (m_st == 0 || m_st == 2) && ok && mis == 0);
      chk("cmp voted_q", voted_q, (m_st == 3 || !ok) ? m_held : v);
      chk("cmp state", state, m_st);
      chk("cmp mask", mask, m_mask);
      chk("cmp resync", resync, m_rs);
      chk("cmp err_count", err_count, m_err);
      chk("cmp irq", irq, m_irq);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic setq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    q_1 = a; q_2 = b; q_3 = c;
  endtask

  initial begin
    rst = 1; enable_in = 1; irq_ack = 0; clear = 0;
    setq(8'h05, 8'h05, 8'h05);
    #1;
    chk("reset state", state, 0);
    chk("reset mask", mask, 0);
    chk("reset resync", resync, 0);
    step(2);
    rst = 0; run = 1;
    chk("normal cnt_enable", cnt_enable, 1);
    chk("normal voted_q", voted_q, 8'h05);
    chk("normal state", state, 0);
    chk("normal irq", irq, 0);
    chk("normal err", err_count, 0);
    step(1);

    // Single transient mismatch on replica 2.
    setq(8'h10, 8'h40, 8'h10);
    #1 chk("mismatch gates enable", cnt_enable, 0);
    step(1);
    chk("resync strobe", resync, 3'b010);
    chk("resync state", state, 1);
    chk("resync enable", cnt_enable, 0);
    chk("err after one", err_count, 1);
    q_2 = 8'h10;
    step(1);
    chk("back to normal", state, 0);
    chk("strobe one cycle", resync, 0);

    // Replica 3 stuck: four failed attempts mask it.
    q_3 = 8'hFF;
    step(8);
    chk("stuck mask", mask, 3'b100);
    chk("stuck state", state, 2);
    chk("stuck irq", irq, 1);
    chk("stuck err", err_count, 5);
    q_3 = 8'h77;
    step(2);
    chk("masked ignored state", state, 2);
    chk("masked ignored enable", cnt_enable, 1);
    irq_ack = 1; step(1); irq_ack = 0;
    chk("irq ack", irq, 0);

    // Degraded pair disagrees -> fail-safe hold.
    setq(8'h20, 8'h20, 8'h77);
    step(1);
    q_2 = 8'h21;
    #1 chk("degraded split voted", voted_q, 8'h20);
    step(1);
    chk("failsafe state", state, 3);
    chk("failsafe enable", cnt_enable, 0);
    chk("failsafe voted", voted_q, 8'h20);
    chk("failsafe irq", irq, 1);
    setq(8'h55, 8'h55, 8'h55);
    step(1);
    chk("failsafe frozen", voted_q, 8'h20);

    // Software recovery.
    setq(8'h33, 8'h33, 8'h33);
    clear = 1; step(1); clear = 0;
    chk("clear resync", resync, 3'b111);
    chk("clear mask", mask, 0);
    chk("clear err", err_count, 0);
    chk("clear state", state, 1);
    chk("clear keeps irq", irq, 1);
    step(1);
    chk("clear then normal", state, 0);
    irq_ack = 1; step(1); irq_ack = 0;

    // Three-way disagreement from NORMAL.
    setq(8'h01, 8'h02, 8'h03);
    step(1);
    chk("nomaj state", state, 3);
    chk("nomaj held", voted_q, 8'h33);
    setq(8'h44, 8'h44, 8'h44);
    clear = 1; step(1); clear = 0;
    chk("clear2 resync", resync, 3'b111);
    chk("clear2 state", state, 1);
    step(1);
    chk("clear2 normal", state, 0);
    chk("clear2 voted", voted_q, 8'h44);
    irq_ack = 1; step(1); irq_ack = 0;

    // 300 recovered mismatch events rotate across replicas.
    for (int k = 0; k < 300; k++) begin
      setq(8'h50, 8'h50, 8'h50);
      if (k % 3 == 0) q_1 = 8'h51;
      else if (k % 3 == 1) q_2 = 8'h51;
      else q_3 = 8'h51;
      step(1);
      setq(8'h50, 8'h50, 8'h50);
      step(1);
    end
    chk("err saturated", err_count, 8'hFF);
    chk("no mask from transients", mask, 0);
    chk("irq idle before", irq, 0);

    // Degraded entry coinciding with irq_ack: set wins.
    q_1 = 8'h99;
    for (int a = 1; a <= 4; a++) begin
      step(1);
      if (a == 4) irq_ack = 1;
      step(1);
      irq_ack = 0;
    end
    chk("ack race mask", mask, 3'b001);
    chk("ack race state", state, 2);
    chk("ack race irq", irq, 1);
    chk("err stays sat", err_count, 8'hFF);

    // Reset in the middle of a resync strobe.
    setq(8'h50, 8'h50, 8'h50);
    clear = 1; step(1); clear = 0;
    chk("pre-reset strobe", resync, 3'b111);
    #2 rst = 1;
    #1;
    chk("async reset strobe", resync, 0);
    chk("async reset state", state, 0);
    chk("async reset irq", irq, 0);
    @(posedge clk); #1 rst = 0;
    step(2);
    chk("post reset mask", mask, 0);
    chk("post reset enable", cnt_enable, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
